// File: rtl/imm26_field_decoder.sv
// Splits a packed immediate word into rs1/rd/imm16, checks the sign byte, and buffers results in a DEPTH-entry FIFO.
// Optional build macro STRICT_SIGN_EN: words with a bad sign byte are counted but dropped instead of enqueued.
module imm26_field_decoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_rs1,
  output logic [3:0]       out_rd,
  output logic [15:0]      out_imm16,
  output logic             out_sign_err,
  output logic [CNT_W-1:0] decode_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  typedef struct packed {
    logic [3:0]  rs1;
    logic [3:0]  rd;
    logic [15:0] imm16;
    logic        sign_err;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        in_e, head_q, head_n;
  logic [AW-1:0] wptr, rptr, rptr_n, wptr_n;
  logic [AW:0]   cnt, cnt_n;
  logic          serr, acc, wr, rd_en;

  assign in_ready  = !reset && (cnt != DEPTH_C);
  assign out_valid = (cnt != '0);
  // Expected sign byte is the replicated rd[3] bit.
  assign serr  = (in_word[31:24] != {8{in_word[19]}});
  assign acc   = in_valid && in_ready && !flush;
  assign rd_en = out_valid && out_ready && !flush;

`ifdef STRICT_SIGN_EN
  assign wr = acc && !serr;
  assign in_e = '{rs1: in_word[23:20], rd: in_word[19:16], imm16: in_word[15:0], sign_err: 1'b0};
`else
  assign wr = acc;
  assign in_e = '{rs1: in_word[23:20], rd: in_word[19:16], imm16: in_word[15:0], sign_err: serr};
`endif

  always_comb begin
    rptr_n = rptr + AW'(rd_en);
    wptr_n = wptr + AW'(wr);
    cnt_n  = cnt + (AW+1)'(wr) - (AW+1)'(rd_en);
    if (flush) begin
      rptr_n = '0;
      wptr_n = '0;
      cnt_n  = '0;
    end
    // Head register tracks the next-state head; holds its last value when the FIFO empties.
    head_n = head_q;
    if (!flush && cnt_n != '0)
      head_n = (wr && rptr_n == wptr) ? in_e : mem[rptr_n];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= in_e;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      rptr       <= '0;
      wptr       <= '0;
      head_q     <= '0;
      decode_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      cnt    <= cnt_n;
      rptr   <= rptr_n;
      wptr   <= wptr_n;
      head_q <= head_n;
      if (acc && decode_cnt != '1)         decode_cnt <= decode_cnt + 1'b1;
      if (acc && serr && err_cnt != '1)    err_cnt    <= err_cnt + 1'b1;
    end
  end

  assign out_rs1      = head_q.rs1;
  assign out_rd       = head_q.rd;
  assign out_imm16    = head_q.imm16;
  assign out_sign_err = head_q.sign_err;
endmodule

// File: tb/tb_imm26_field_decoder.sv
// Directed bench for imm26_field_decoder (DEPTH=2, CNT_W=16); honours STRICT_SIGN_EN if defined.
module tb_imm26_field_decoder;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_sign_err;
  logic [31:0] in_word;
  logic [3:0]  out_rs1, out_rd;
  logic [15:0] out_imm16;
  logic [15:0] decode_cnt, err_cnt;
  int          n_tests = 0, n_fail = 0;

  imm26_field_decoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rd(out_rd), .out_imm16(out_imm16), .out_sign_err(out_sign_err),
    .decode_cnt(decode_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {out_rs1, out_rd, out_imm16, out_sign_err}, 0);
    chk("rst_dcnt", decode_cnt, 0);
    chk("rst_ecnt", err_cnt, 0);
    reset = 1'b0;
    tick();
    chk("rel_in_ready", in_ready, 1);

    // basic decode
    out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h0005_1234;
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_rs1", out_rs1, 4'h0);
    chk("t1_rd", out_rd, 4'h5);
    chk("t1_imm", out_imm16, 16'h1234);
    chk("t1_serr", out_sign_err, 0);
    chk("t1_dcnt", decode_cnt, 1);
    in_word = 32'hFFFF_FFFF;
    tick();
    chk("t2_fields", {out_rs1, out_rd, out_imm16}, 24'hFF_FFFF);
    chk("t2_serr", out_sign_err, 0);
    in_word = 32'h00FF_FFFF;
    tick();
`ifdef STRICT_SIGN_EN
    chk("t2_err_valid", out_valid, 0);
    chk("t2_err_serr", out_sign_err, 0);
`else
    chk("t2_err_valid", out_valid, 1);
    chk("t2_err_serr", out_sign_err, 1);
`endif
    chk("t2_ecnt", err_cnt, 1);
    chk("t2_dcnt", decode_cnt, 3);
    in_valid = 1'b0;
    tick();
    chk("t2_empty", out_valid, 0);
    chk("t2_hold", {out_rs1, out_imm16}, 20'hF_FFFF);

    // fill to full, back-pressure, drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h0012_0001;
    tick();
    chk("t3_rdy1", in_ready, 1);
    chk("t3_head0", out_imm16, 16'h0001);
    in_word = 32'h0034_0002;
    tick();
    chk("t3_full", in_ready, 0);
    in_word = 32'h0056_0003;
    tick();
    chk("t3_held_head", out_imm16, 16'h0001);
    chk("t3_held_dcnt", decode_cnt, 5);
    out_ready = 1'b1;
    tick();
    chk("t3_drain1", out_imm16, 16'h0002);
    chk("t3_rdy_back", in_ready, 1);
    tick();
    chk("t3_drain2", out_imm16, 16'h0003);
    chk("t3_drain2_rs1", out_rs1, 4'h5);
    in_valid = 1'b0;
    tick();
    chk("t3_empty", out_valid, 0);
    chk("t3_dcnt", decode_cnt, 6);

    // steady push+pop at one entry
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h0070_0100;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_word = 32'h0070_0101 + 32'(i);
      tick();
      chk("t4_valid", out_valid, 1);
      chk("t4_order", out_imm16, 16'h0101 + 16'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("t4_empty", out_valid, 0);
    chk("t4_dcnt", decode_cnt, 15);

    // flush with push in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h0012_0AAA;
    tick();
    in_word = 32'h0012_0BBB;
    tick();
    chk("t5_full", in_ready, 0);
    chk("t5_dcnt_pre", decode_cnt, 17);
    flush = 1'b1; in_word = 32'h0012_0CCC;
    tick();
    flush = 1'b0;
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_rdy", in_ready, 1);
    chk("t5_flush_dcnt", decode_cnt, 17);
    in_word = 32'h0012_0DDD;
    tick();
    flush = 1'b1; in_word = 32'h0012_0EEE;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush2_valid", out_valid, 0);
    chk("t5_flush2_dcnt", decode_cnt, 18);
    tick();
    chk("t5_no_ghost", out_valid, 0);

    // async reset mid-burst
    in_valid = 1'b1; in_word = 32'h0012_1111;
    tick();
    in_word = 32'h0012_2222;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_dcnt", decode_cnt, 0);
    chk("t6_async_ecnt", err_cnt, 0);
    chk("t6_async_rdy", in_ready, 0);
    chk("t6_async_imm", out_imm16, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("t6_rel_rdy", in_ready, 1);
    in_valid = 1'b1; in_word = 32'h0000_0000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_valid", out_valid, 1);
    chk("t6_fields", {out_rs1, out_rd, out_imm16, out_sign_err}, 0);
    chk("t6_dcnt", decode_cnt, 1);
    chk("t6_ecnt", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
